// File: rtl/bootrom_copier.sv
`default_nettype none
// ============================================================================
// Module   : bootrom_copier
// Purpose  : Power-up shadow copier. Reads WORD_COUNT words from the boot ROM
//            one at a time and writes each into RAM through a handshaked write
//            port. Non-pipelined: READ -> WAIT (ROM_LATENCY) -> WRITE per word.
// Ports    : clk          system clock, rising edge
//            rst          asynchronous, active-low reset
//            start        begin a copy (honoured only in IDLE or DONE)
//            busy, done   copy status
//            rom_read_op  one-cycle ROM read strobe
//            rom_addr     ROM byte address
//            rom_data     ROM read data, ROM_LATENCY cycles after the strobe
//            ram_we       RAM write request
//            ram_addr     RAM byte address
//            ram_data     RAM write data
//            ram_be       RAM byte enables
//            ram_ready    RAM accepts the write when ram_we & ram_ready
// Revision : 1.0 - initial release
// ============================================================================
module bootrom_copier #(
    parameter logic [31:0] SRC_BASE    = 32'h0000_0000,
    parameter logic [31:0] DST_BASE    = 32'h8000_0000,
    parameter int unsigned WORD_COUNT  = 1024,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rom_read_op,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data,
    output logic [3:0]  ram_be,
    input  logic        ram_ready
);

    typedef logic [2:0] state_t;
    localparam state_t c_IDLE  = 3'd0;
    localparam state_t c_READ  = 3'd1;
    localparam state_t c_WAIT  = 3'd2;
    localparam state_t c_WRITE = 3'd3;
    localparam state_t c_DONE  = 3'd4;

    localparam logic [15:0] c_LAST     = (WORD_COUNT == 0) ? 16'd0 : 16'(WORD_COUNT - 1);
    localparam logic [1:0]  c_LAT_LAST = 2'(ROM_LATENCY - 1);

    state_t      r_state_q,    w_state_d;
    logic [15:0] r_cnt_q,      w_cnt_d;
    logic [1:0]  r_lat_q,      w_lat_d;
    logic        r_busy_q,     w_busy_d;
    logic        r_done_q,     w_done_d;
    logic        r_rd_q,       w_rd_d;
    logic        r_we_q,       w_we_d;
    logic [3:0]  r_be_q,       w_be_d;
    logic [31:0] r_rom_addr_q, w_rom_addr_d;
    logic [31:0] r_ram_addr_q, w_ram_addr_d;
    logic [31:0] r_ram_data_q, w_ram_data_d;

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_lat_d      = r_lat_q;
        w_rom_addr_d = r_rom_addr_q;
        w_ram_addr_d = r_ram_addr_q;
        w_ram_data_d = r_ram_data_q;

        case (r_state_q)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_cnt_d   = 16'd0;
                    // An empty copy completes immediately with no bus traffic.
                    w_state_d = (WORD_COUNT == 0) ? c_DONE : c_READ;
                end
            end
            c_READ: begin
                w_state_d = c_WAIT;
                w_lat_d   = 2'd0;
            end
            c_WAIT: begin
                if (r_lat_q == c_LAT_LAST) begin
                    // The edge leaving the last WAIT cycle is the only point
                    // where rom_data is trusted; it becomes the write data.
                    w_state_d    = c_WRITE;
                    w_ram_data_d = rom_data;
                    w_ram_addr_d = DST_BASE + {14'b0, r_cnt_q, 2'b00};
                end else begin
                    w_lat_d = r_lat_q + 2'd1;
                end
            end
            c_WRITE: begin
                if (ram_ready) begin
                    if (r_cnt_q == c_LAST) begin
                        w_state_d = c_DONE;
                    end else begin
                        w_cnt_d   = r_cnt_q + 16'd1;
                        w_state_d = c_READ;
                    end
                end
            end
            default: w_state_d = c_IDLE;
        endcase

        if (w_state_d == c_READ) begin
            w_rom_addr_d = SRC_BASE + {14'b0, w_cnt_d, 2'b00};
        end

        // Outputs are decoded from the next state so they register alongside it.
        w_busy_d = (w_state_d == c_READ) || (w_state_d == c_WAIT) || (w_state_d == c_WRITE);
        w_done_d = (w_state_d == c_DONE);
        w_rd_d   = (w_state_d == c_READ);
        w_we_d   = (w_state_d == c_WRITE);
        w_be_d   = (w_state_d == c_WRITE) ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q    <= c_IDLE;
            r_cnt_q      <= 16'd0;
            r_lat_q      <= 2'd0;
            r_busy_q     <= 1'b0;
            r_done_q     <= 1'b0;
            r_rd_q       <= 1'b0;
            r_we_q       <= 1'b0;
            r_be_q       <= 4'h0;
            r_rom_addr_q <= 32'd0;
            r_ram_addr_q <= 32'd0;
            r_ram_data_q <= 32'd0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_lat_q      <= w_lat_d;
            r_busy_q     <= w_busy_d;
            r_done_q     <= w_done_d;
            r_rd_q       <= w_rd_d;
            r_we_q       <= w_we_d;
            r_be_q       <= w_be_d;
            r_rom_addr_q <= w_rom_addr_d;
            r_ram_addr_q <= w_ram_addr_d;
            r_ram_data_q <= w_ram_data_d;
        end
    end

    assign busy        = r_busy_q;
    assign done        = r_done_q;
    assign rom_read_op = r_rd_q;
    assign rom_addr    = r_rom_addr_q;
    assign ram_we      = r_we_q;
    assign ram_be      = r_be_q;
    assign ram_addr    = r_ram_addr_q;
    assign ram_data    = r_ram_data_q;

endmodule
`default_nettype wire

// File: tb/tb_bootrom_copier.sv
`default_nettype none
// ============================================================================
// Module   : tb_bootrom_copier
// Purpose  : Self-checking bench for bootrom_copier. Four copier instances
//            with different parameter sets share one clock and reset; a
//            behavioural ROM answers each read after its latency, and each
//            copy is checked cycle by cycle against an event timeline derived
//            from the per-word cost (2 + latency + stall cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bootrom_copier;

    // Instance k parameters; packed arrays are listed from index 3 down to 0.
    localparam logic [3:0][31:0] SRC_A = {32'hFFFF_FFF8, 32'h0000_0040, 32'h0000_1000, 32'h0000_0000};
    localparam logic [3:0][31:0] DST_A = {32'hFFFF_FFF0, 32'h8000_0000, 32'h9000_0100, 32'h8000_0000};
    localparam logic [3:0][15:0] WC_A  = {16'd4, 16'd0, 16'd2, 16'd4};
    localparam logic [3:0][1:0]  LAT_A = {2'd1, 2'd1, 2'd2, 2'd1};

    logic        clk;
    logic        rst;
    logic        start       [4];
    logic        busy        [4];
    logic        done        [4];
    logic        rom_read_op [4];
    logic [31:0] rom_addr    [4];
    logic [31:0] rom_data    [4];
    logic        ram_we      [4];
    logic [31:0] ram_addr    [4];
    logic [31:0] ram_data    [4];
    logic [3:0]  ram_be      [4];
    logic        ram_ready   [4];

    logic        p_op   [4];
    logic [31:0] p_addr [4];
    logic [31:0] seed   [4];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bootrom_copier #(
            .SRC_BASE   (SRC_A[g]),
            .DST_BASE   (DST_A[g]),
            .WORD_COUNT (int'(WC_A[g])),
            .ROM_LATENCY(int'(LAT_A[g]))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .rom_read_op(rom_read_op[g]),
            .rom_addr   (rom_addr[g]),
            .rom_data   (rom_data[g]),
            .ram_we     (ram_we[g]),
            .ram_addr   (ram_addr[g]),
            .ram_data   (ram_data[g]),
            .ram_be     (ram_be[g]),
            .ram_ready  (ram_ready[g])
        );
    end

    // ROM contents: a scrambled function of the byte address.
    function automatic logic [31:0] rom_val(input int k, input logic [31:0] a);
        return seed[k] ^ (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    // Behavioural ROM: data is valid only in the cycle exactly LAT cycles
    // after a strobe; every other cycle carries random junk.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            p_op[k]   <= rom_read_op[k];
            p_addr[k] <= rom_addr[k];
            if (LAT_A[k] == 2'd1)
                rom_data[k] <= rom_read_op[k] ? rom_val(k, rom_addr[k]) : $urandom;
            else
                rom_data[k] <= p_op[k] ? rom_val(k, p_addr[k]) : $urandom;
        end
    end

    task automatic chk(input string tag, input int k, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut=%0d cycle=%0d observed=%h expected=%h", tag, k, c, obs, exp);
        end
    endtask

    // Runs one copy on instance k. Cycle 0 is the cycle with start high.
    // mode 0: ram_ready always 1; mode 1: stall write number stall_word for
    // stall_len cycles; mode 2: random ram_ready. poke_at re-pulses start.
    task automatic run_copy(input int k, input int mode, input int stall_word,
                            input int stall_len, input int poke_at);
        int i, t_read, stalls_w, done_at, nwc, lat;
        logic busy_exp, rd_exp, we_exp, rdy;
        logic [31:0] a_src, a_dst;
        nwc      = int'(WC_A[k]);
        lat      = int'(LAT_A[k]);
        i        = 0;
        t_read   = 1;
        stalls_w = 0;
        done_at  = (nwc == 0) ? 1 : -1;
        @(negedge clk);
        start[k]     = 1'b1;
        ram_ready[k] = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            busy_exp = (done_at < 0);
            rd_exp   = busy_exp && (c == t_read);
            we_exp   = busy_exp && (c >= t_read + 1 + lat);
            a_src    = SRC_A[k] + 32'(4 * i);
            a_dst    = DST_A[k] + 32'(4 * i);
            chk("busy",        k, c, 32'(busy[k]),        32'(busy_exp));
            chk("done",        k, c, 32'(done[k]),        32'(!busy_exp));
            chk("rom_read_op", k, c, 32'(rom_read_op[k]), 32'(rd_exp));
            chk("ram_we",      k, c, 32'(ram_we[k]),      32'(we_exp));
            chk("ram_be",      k, c, 32'(ram_be[k]),      we_exp ? 32'hF : 32'h0);
            if (rd_exp)
                chk("rom_addr", k, c, rom_addr[k], a_src);
            if (we_exp) begin
                chk("ram_addr", k, c, ram_addr[k], a_dst);
                chk("ram_data", k, c, ram_data[k], rom_val(k, a_src));
            end
            case (mode)
                1:       rdy = !(we_exp && (i == stall_word) && (stalls_w < stall_len));
                2:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = 1'b1;
            endcase
            if (we_exp && !rdy)
                stalls_w++;
            ram_ready[k] = rdy;
            start[k]     = (c == poke_at);
            if (we_exp && rdy) begin
                i++;
                t_read = c + 1;
                if (i == nwc)
                    done_at = c + 1;
            end
            if (done_at >= 0 && c >= done_at + 2)
                break;
        end
        start[k]     = 1'b0;
        ram_ready[k] = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start[k]     = 1'b0;
            ram_ready[k] = 1'b1;
            seed[k]      = $urandom;
        end
        repeat (3) @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            chk("rst_busy",     k, 0, 32'(busy[k]),        32'h0);
            chk("rst_done",     k, 0, 32'(done[k]),        32'h0);
            chk("rst_rd",       k, 0, 32'(rom_read_op[k]), 32'h0);
            chk("rst_we",       k, 0, 32'(ram_we[k]),      32'h0);
            chk("rst_be",       k, 0, 32'(ram_be[k]),      32'h0);
            chk("rst_rom_addr", k, 0, rom_addr[k],         32'h0);
            chk("rst_ram_addr", k, 0, ram_addr[k],         32'h0);
            chk("rst_ram_data", k, 0, ram_data[k],         32'h0);
        end
        rst = 1'b1;

        run_copy(0, 0, 0, 0, -1);   // basic 4-word copy
        run_copy(0, 1, 1, 5, -1);   // restart from DONE, 5-cycle stall on 2nd write
        run_copy(0, 0, 0, 0, 5);    // start pulsed while busy
        run_copy(0, 2, 0, 0, -1);   // random backpressure
        run_copy(1, 0, 0, 0, -1);   // two-cycle ROM latency
        run_copy(1, 2, 0, 0, -1);
        run_copy(2, 0, 0, 0, -1);   // empty copy
        run_copy(2, 0, 0, 0, -1);
        run_copy(3, 0, 0, 0, -1);   // source and destination wrap
        run_copy(3, 2, 0, 0, -1);

        // Reset in the middle of a stalled write.
        @(negedge clk);
        start[0]     = 1'b1;
        ram_ready[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (ram_we[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_we", 0, n, 32'(ram_we[0]), 32'h1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 0, 0, 32'(busy[0]),        32'h0);
        chk("arst_rd",   0, 0, 32'(rom_read_op[0]), 32'h0);
        chk("arst_we",   0, 0, 32'(ram_we[0]),      32'h0);
        chk("arst_be",   0, 0, 32'(ram_be[0]),      32'h0);
        chk("arst_addr", 0, 0, ram_addr[0],         32'h0);
        chk("arst_data", 0, 0, ram_data[0],         32'h0);
        for (int k = 0; k < 4; k++)
            chk("arst_done", k, 0, 32'(done[k]), 32'h0);
        @(negedge clk);
        rst          = 1'b1;
        ram_ready[0] = 1'b1;
        run_copy(0, 0, 0, 0, -1);   // fresh copy from word 0 after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bootrom_copier.md
Name: bootrom_copier

Overview:
- Bus initiator that drives the boot ROM read port (read_op / address / data) and copies a fixed block of ROM words into RAM through a ready-handshaked write port.
- Sits between the boot ROM controller's read port and the SRAM controller's write port.
- Used at power-up to shadow boot code into RAM before the CPU is released.
- Processes one word at a time, non-pipelined. The ROM read latency is fixed by parameter.

Parameters:
- SRC_BASE, 32'h0000_0000, byte address of the first ROM word; word aligned.
- DST_BASE, 32'h8000_0000, byte address of the first RAM word; word aligned.
- WORD_COUNT, 1024, number of 32-bit words to copy; range 0..65535.
- ROM_LATENCY, 1, cycles from a sampled rom_read_op to valid rom_data; 1 or 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- start  in  1  begin a copy; sampled only in IDLE or DONE.
- busy  out  1  high while a copy is in progress.
- done  out  1  high from copy completion until the next accepted start or reset.
- rom_read_op  out  1  one-cycle read strobe to the boot ROM.
- rom_addr  out  32  byte address of the ROM read.
- rom_data  in  32  ROM read data, valid ROM_LATENCY cycles after the strobe.
- ram_we  out  1  write request.
- ram_addr  out  32  RAM byte address.
- ram_data  out  32  RAM write data.
- ram_be  out  4  byte enables; always 4'hF while ram_we=1, else 0.
- ram_ready  in  1  RAM accepts the write in any cycle where ram_we=1 and ram_ready=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; word counter=0.
  - busy, done, rom_read_op, ram_we = 0.
  - rom_addr, ram_addr, ram_data = 0; ram_be = 0.
  - Reset mid-copy abandons the copy immediately. Any pending RAM write is dropped with no completion.
- FSM states:
  - IDLE: outputs idle. start=1 → READ; counter=0; done cleared.
  - READ (1 cycle): rom_read_op=1; rom_addr = SRC_BASE + 4*counter. Next → WAIT.
  - WAIT (ROM_LATENCY cycles, counted by a latency counter): rom_read_op=0. On the rising edge ending the last WAIT cycle, capture rom_data into the data register. Next → WRITE.
  - WRITE: ram_we=1; ram_be=4'hF; ram_addr = DST_BASE + 4*counter; ram_data = captured word.
    - ram_addr and ram_data stay stable while ram_ready=0; no timeout.
    - On accept: if counter == WORD_COUNT-1 → DONE; else counter+1 and → READ.
  - DONE: done=1; busy=0. start=1 → READ with counter=0 and done cleared on the same edge.
- busy=1 in READ, WAIT and WRITE.
- start is ignored while busy.
- WORD_COUNT=0: an accepted start goes IDLE → DONE directly. No ROM or RAM traffic.
- Addresses are computed modulo 2^32; wrap-around is silent.
- Counter is 16 bits.
- Timing:
  - Per-word latency with ram_ready held high: 2 + ROM_LATENCY cycles.
  - Each ram_ready low cycle adds one cycle.
- rom_data is ignored outside the capture edge.
- ram_ready is ignored when ram_we=0.
- All outputs are registered or decoded from state; there is no combinational path from any input to any output.

Test Plan:
1. Reset mid-copy: assert rst low while in WRITE with ram_ready=0 → ram_we, busy, done, rom_read_op drop to 0 asynchronously. After release, a new start copies again from word 0.
2. Basic copy, WORD_COUNT=4, ROM_LATENCY=1, ram_ready tied 1, ROM returns 32'hA000_0000+index; start pulsed in cycle 0:
   - rom_read_op in cycles 1, 4, 7, 10 with rom_addr 0x0, 0x4, 0x8, 0xC.
   - ram_we in cycles 3, 6, 9, 12 with ram_addr 0x8000_0000..0x8000_000C and ram_data A0000000..A0000003.
   - busy high in cycles 1..12; done=1 from cycle 13.
3. Backpressure: hold ram_ready=0 for 5 cycles during the 2nd write → ram_we, ram_addr, ram_data stable throughout; total copy time grows by exactly 5 cycles; all data correct.
4. ROM_LATENCY=2, WORD_COUNT=2 → reads in cycles 1 and 5; writes in cycles 4 and 8. Data is captured from the second cycle after each strobe, not the first.
5. Edge cases:
   - WORD_COUNT=0 → done one cycle after start; no strobes.
   - start pulsed while busy → no effect.
   - start in DONE → a full second copy runs with identical results.
6. Wrap: SRC_BASE=32'hFFFF_FFF8, WORD_COUNT=4 → rom_addr sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
